median_window_reader: RTL and testbench
=======================================

# median_window_reader

Read-side sequencer for the median-result window BRAM. After upstream has filled all (2*FILTER+1)^2 cells of the BRAM, a start pulse makes this block sweep the BRAM read address from 0 to N-1. It compensates for the BRAM's one-cycle registered read latency. It streams the cells out on a valid/ready interface with first/last markers and the cell index, for the MRELBP sampling stage downstream.

## Interface
- WIDTH, 8, bits per cell; must match the BRAM.
- FILTER, 3, median filter radius; N = (2*FILTER+1)^2 cells, AW = $clog2(N).
- i_clk  in  1  global clock; all logic is on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  one-cycle pulse meaning the window is fully written and readout may begin; ignored unless in IDLE.
- o_raddr  out  AW  read address to the BRAM.
- i_rdata  in  WIDTH  BRAM read data, valid one cycle after o_raddr is sampled.
- o_data  out  WIDTH  output cell value.
- o_idx  out  AW  raster index of o_data (row*(2F+1)+col).
- o_first  out  1  high with index 0.
- o_last  out  1  high with index N-1.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the beat; the transfer happens when o_valid && i_ready.
- o_busy  out  1  high from the cycle after i_start until o_done.
- o_done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- The FSM has states IDLE, READ, DRAIN and DONE.
  - IDLE: on i_start, clear the address counter and go to READ.
  - READ: issue reads while the issue condition holds; after issuing address N-1, go to DRAIN.
  - DRAIN: wait until nothing is in flight and the buffer is empty, then go to DONE.
  - DONE: assert o_done for one cycle, then return to IDLE.
- Issue condition: occupancy + inflight - pop < 2, where pop = o_valid && i_ready. This sustains one beat per cycle without overflow.
- inflight is a 1-bit register: it is set on the cycle after an issue and holds while the BRAM data is pending. The BRAM data and its index are pushed into the buffer on the cycle after the issue.
- o_raddr is the counter value and changes only on issue. It holds its value when no read is issued and equals 0 in IDLE.
- Index, first and last travel through the buffer alongside the data, so the markers always align with their beat.
- Output data is exactly what the BRAM returned; the block does no arithmetic.
- Boundary conditions:
  - Buffer full: no issue.
  - Buffer empty: o_valid=0.
  - Simultaneous push and pop on a full buffer: legal, and the count is unchanged.
  - i_start while busy: ignored, with no restart.
  - i_rst mid-sweep: state IDLE, buffer flushed, inflight cleared, no o_done.
- The address counter stops at N-1 and never wraps inside a sweep. The next sweep reloads it to 0.
- Guaranteeing that BRAM writes are complete before i_start is the upstream's responsibility.

## Timing
- Reset values: o_raddr=0, o_data=0, o_idx=0, o_first=0, o_last=0, o_valid=0, o_busy=0, o_done=0.
- If i_start is sampled at edge E0:
  - READ and o_raddr=0 are in place at E0+1.
  - BRAM data is captured at E0+2.
  - o_valid rises after E0+2, so the latency is 3 cycles from start to first valid.
- With i_ready held high: N consecutive beats, o_done after the edge accepting index N-1, o_busy falling with o_done. The total is N+4 cycles from start to done.
- While o_valid && !i_ready, o_data, o_idx and the markers stay stable.

## Structure
- Package median_pkg:
  - N and AW localparam functions of FILTER.
  - The state enum typedef reader_state_t.
  - A beat struct {data, idx, first, last}.
- Sub-module median_skid_fifo: a 2-entry, beat-wide register FIFO with push, pop, full, empty and count.
- The reader top contains the FSM, address counter, inflight flag and issue logic.

## Test plan
- Reset, then pre-load the BRAM with cell k = k+10 and pulse i_start with i_ready=1. Required response:
  - beats 10..58 on consecutive cycles with idx 0..48;
  - first on idx 0 and last on idx 48;
  - first valid 3 cycles after start and o_done once.
- Random i_ready (50%). Required response: all 49 beats in order with no loss or duplication, data stable while stalled, and o_raddr never exceeding 48.
- i_ready=0 for 10 cycles after the first valid. Required response: exactly 2 beats buffered, o_raddr held at 2, and the stream resuming at idx 0 without gaps.
- i_start pulsed again at beat 20. Required response: ignored, and the sweep completes normally.
- i_rst asserted at beat 30. Required response:
  - all outputs 0 on the next cycle with no o_done;
  - a new i_start restarts at idx 0.
- FILTER=1 (N=9) build. Required response: 9 beats, last on idx 8, and a 13-cycle start-to-done with i_ready=1.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and size helpers for the median-window read sequencer.
// The window is (2*FILTER+1)^2 cells; beats carry the cell value plus raster markers.
package median_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_FILTER = 3;

  function automatic int calcCells(input int filter);
    return (2 * filter + 1) * (2 * filter + 1);
  endfunction

  function automatic int calcAddrW(input int filter);
    return $clog2(calcCells(filter));
  endfunction

  localparam int DEFAULT_AW = calcAddrW(DEFAULT_FILTER);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } reader_state_t;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
    logic [DEFAULT_AW-1:0]    idx;
    logic                     first;
    logic                     last;
  } beat_t;

endpackage

// File: rtl/median_window_reader_if.sv
// Bundles the BRAM read port and the downstream valid/ready stream of the reader.
// The reader side is the master; the BRAM/consumer side is the slave.
interface median_window_reader_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
);

  logic             i_start;
  logic [AW-1:0]    o_raddr;
  logic [WIDTH-1:0] i_rdata;
  logic [WIDTH-1:0] o_data;
  logic [AW-1:0]    o_idx;
  logic             o_first;
  logic             o_last;
  logic             o_valid;
  logic             i_ready;
  logic             o_busy;
  logic             o_done;

  modport master (
    input  i_start, i_rdata, i_ready,
    output o_raddr, o_data, o_idx, o_first, o_last, o_valid, o_busy, o_done
  );

  modport slave (
    output i_start, i_rdata, i_ready,
    input  o_raddr, o_data, o_idx, o_first, o_last, o_valid, o_busy, o_done
  );

endinterface

// File: rtl/median_skid_fifo.sv
// Two-entry register FIFO that absorbs the BRAM read latency so the stream
// can run one beat per cycle; a push and pop together on a full FIFO is legal.
module median_skid_fifo
  import median_pkg::*;
#(
  parameter type beat_t = median_pkg::beat_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  beat_t      pushBeat_i,
  input  logic       pop_i,
  output beat_t      popBeat_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  beat_t      mem_q [2];
  logic       wrPtr_q;
  logic       rdPtr_q;
  logic [1:0] count_q;
  logic       doPush;
  logic       doPop;

  assign doPop  = pop_i && (count_q != 2'd0);
  assign doPush = push_i && ((count_q != 2'd2) || doPop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushBeat_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (doPop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_q + 2'(doPush) - 2'(doPop);
    end
  end

  assign popBeat_o = mem_q[rdPtr_q];
  assign full_o    = (count_q == 2'd2);
  assign empty_o   = (count_q == 2'd0);
  assign count_o   = count_q;

endmodule

// File: rtl/median_window_reader.sv
// Sweeps the median-window BRAM from cell 0 to N-1 after a start pulse and
// streams the cells out with raster index and first/last markers.
module median_window_reader
  import median_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int FILTER = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  median_window_reader_if.master bus
);

  localparam int            N         = calcCells(FILTER);
  localparam int            AW        = calcAddrW(FILTER);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    idx;
    logic             first;
    logic             last;
  } cellBeat_t;

  reader_state_t state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] pendIdx_q;
  logic          inflight_q;
  logic          busy_q;
  logic          done_q;

  logic          pop;
  logic          issue;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [1:0]    fifoCount;
  cellBeat_t     pushBeat;
  cellBeat_t     headBeat;

  // A read may go out only if the beat it returns is guaranteed a FIFO slot.
  assign pop   = !fifoEmpty && bus.i_ready;
  assign issue = (state_q == READ) && (!fifoFull || pop) &&
                 (({1'b0, fifoCount} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  assign pushBeat.data  = bus.i_rdata;
  assign pushBeat.idx   = pendIdx_q;
  assign pushBeat.first = (pendIdx_q == '0);
  assign pushBeat.last  = (pendIdx_q == LAST_ADDR);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pendIdx_q  <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      done_q     <= 1'b0;
      if (issue) begin
        pendIdx_q <= addr_q;
      end
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          if (issue) begin
            if (addr_q == LAST_ADDR) begin
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!inflight_q && fifoEmpty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          addr_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  median_skid_fifo #(
    .beat_t(cellBeat_t)
  ) skidFifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push_i    (inflight_q),
    .pushBeat_i(pushBeat),
    .pop_i     (pop),
    .popBeat_o (headBeat),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty),
    .count_o   (fifoCount)
  );

  assign bus.o_raddr = addr_q;
  assign bus.o_data  = headBeat.data;
  assign bus.o_idx   = headBeat.idx;
  assign bus.o_first = headBeat.first;
  assign bus.o_last  = headBeat.last;
  assign bus.o_valid = !fifoEmpty;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_median_window_reader.sv
// Directed bench for median_window_reader: a FILTER=3 instance for the main
// sweeps and a FILTER=1 instance for the small-window timing.
module tb_median_window_reader;
  import median_pkg::*;

  localparam int AW_A = calcAddrW(3);
  localparam int AW_B = calcAddrW(1);

  logic clock;
  logic reset;
  logic sel;
  logic startReq;
  logic readyReq;
  int   checkCount;
  int   errorCount;

  logic [7:0] memA [64];
  logic [7:0] memB [16];

  median_window_reader_if #(.WIDTH(8), .AW(AW_A)) busA ();
  median_window_reader_if #(.WIDTH(8), .AW(AW_B)) busB ();

  median_window_reader #(.WIDTH(8), .FILTER(3)) dutA (
    .i_clk(clock),
    .i_rst(reset),
    .bus  (busA)
  );

  median_window_reader #(.WIDTH(8), .FILTER(1)) dutB (
    .i_clk(clock),
    .i_rst(reset),
    .bus  (busB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BRAM models with one-cycle registered read
  always @(posedge clock) begin
    busA.i_rdata <= memA[busA.o_raddr];
    busB.i_rdata <= memB[busB.o_raddr];
  end

  assign busA.i_start = startReq & ~sel;
  assign busB.i_start = startReq & sel;
  assign busA.i_ready = readyReq;
  assign busB.i_ready = readyReq;

  logic [7:0] obsData;
  logic [5:0] obsIdx;
  logic [5:0] obsRaddr;
  logic       obsFirst, obsLast, obsValid, obsBusy, obsDone;

  // Select which instance the checking loop observes
  always_comb begin
    if (sel) begin
      obsData  = busB.o_data;
      obsIdx   = {2'b00, busB.o_idx};
      obsRaddr = {2'b00, busB.o_raddr};
      obsFirst = busB.o_first;
      obsLast  = busB.o_last;
      obsValid = busB.o_valid;
      obsBusy  = busB.o_busy;
      obsDone  = busB.o_done;
    end else begin
      obsData  = busA.o_data;
      obsIdx   = busA.o_idx;
      obsRaddr = busA.o_raddr;
      obsFirst = busA.o_first;
      obsLast  = busA.o_last;
      obsValid = busA.o_valid;
      obsBusy  = busA.o_busy;
      obsDone  = busA.o_done;
    end
  end

  task automatic applyStimulus(input logic start, input logic ready);
    startReq = start;
    readyReq = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_raddr"}, 32'(obsRaddr), 0);
    checkOutput({tag, "_data"},  32'(obsData),  0);
    checkOutput({tag, "_idx"},   32'(obsIdx),   0);
    checkOutput({tag, "_first"}, 32'(obsFirst), 0);
    checkOutput({tag, "_last"},  32'(obsLast),  0);
    checkOutput({tag, "_valid"}, 32'(obsValid), 0);
    checkOutput({tag, "_busy"},  32'(obsBusy),  0);
    checkOutput({tag, "_done"},  32'(obsDone),  0);
  endtask

  // mode 0: ready high, 1: random ready, 2: 10-cycle stall, 3: start while busy, 4: reset at beat 30
  task automatic runSweep(input int mode);
    int         n, expIdx, firstValidN, doneN, doneCount, gapStart, cells;
    logic       prevStall, readyNow, startNow, finished;
    logic [7:0] heldData;
    logic [5:0] heldIdx;
    logic       heldFirst, heldLast;
    cells       = sel ? 9 : 49;
    gapStart    = (mode == 2) ? 12 : 2;
    n           = 0;
    expIdx      = 0;
    firstValidN = -1;
    doneN       = -1;
    doneCount   = 0;
    prevStall   = 1'b0;
    finished    = 1'b0;
    heldData    = '0;
    heldIdx     = '0;
    heldFirst   = 1'b0;
    heldLast    = 1'b0;
    $display("[TB] sweep mode %0d on %0d-cell window", mode, cells);
    @(negedge clock);
    applyStimulus(1'b1, 1'b1);
    @(negedge clock);
    applyStimulus(1'b0, 1'b1);
    checkOutput("busyAfterStart", 32'(obsBusy), 1);
    while (!finished && n < 400) begin
      if (mode == 4 && expIdx == 30) begin
        applyStimulus(1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        checkAllZero("midReset");
        reset = 1'b0;
        @(negedge clock);
        checkOutput("noDoneAfterReset", 32'(obsDone), 0);
        checkOutput("idleAfterReset", 32'(obsValid), 0);
        return;
      end
      case (mode)
        1:       readyNow = 1'($urandom_range(0, 1));
        2:       readyNow = !(n >= 2 && n < 12);
        default: readyNow = 1'b1;
      endcase
      startNow = (mode == 3) && (expIdx == 20) && obsValid;
      applyStimulus(startNow, readyNow);
      if (prevStall) begin
        checkOutput("stallData",  32'(obsData),  32'(heldData));
        checkOutput("stallIdx",   32'(obsIdx),   32'(heldIdx));
        checkOutput("stallFirst", 32'(obsFirst), 32'(heldFirst));
        checkOutput("stallLast",  32'(obsLast),  32'(heldLast));
      end
      if (mode == 2 && n == 11) begin
        checkOutput("stallBuffered", 32'(dutA.skidFifo.count_o), 2);
        checkOutput("stallRaddr", 32'(obsRaddr), 2);
        checkOutput("stallValid", 32'(obsValid), 1);
      end
      checkOutput("raddrInRange", 32'(int'(obsRaddr) <= cells - 1), 1);
      if (mode != 1 && n >= gapStart && expIdx < cells) begin
        checkOutput($sformatf("noGap_n%0d", n), 32'(obsValid), 1);
      end
      if (obsValid) begin
        if (firstValidN < 0) firstValidN = n;
        if (readyNow) begin
          checkOutput($sformatf("data_%0d", expIdx),  32'(obsData),  32'(expIdx + 10));
          checkOutput($sformatf("idx_%0d", expIdx),   32'(obsIdx),   32'(expIdx));
          checkOutput($sformatf("first_%0d", expIdx), 32'(obsFirst), 32'(expIdx == 0));
          checkOutput($sformatf("last_%0d", expIdx),  32'(obsLast),  32'(expIdx == cells - 1));
          expIdx++;
        end
      end
      prevStall = obsValid && !readyNow;
      heldData  = obsData;
      heldIdx   = obsIdx;
      heldFirst = obsFirst;
      heldLast  = obsLast;
      if (obsDone) begin
        doneCount++;
        doneN    = n;
        finished = 1'b1;
        checkOutput("beatsBeforeDone", 32'(expIdx), 32'(cells));
        checkOutput("busyWithDone", 32'(obsBusy), 1);
      end else begin
        @(negedge clock);
        n++;
      end
    end
    checkOutput("doneSeen", 32'(doneCount), 1);
    if (mode == 0 || mode == 3) begin
      checkOutput("firstValidLatency", 32'(firstValidN + 1), 3);
      checkOutput("startToDone", 32'(doneN + 1), 32'(cells + 4));
    end
    applyStimulus(1'b0, 1'b1);
    @(negedge clock);
    checkOutput("donePulseOneCycle", 32'(obsDone), 0);
    checkOutput("busyDropped", 32'(obsBusy), 0);
    checkOutput("raddrIdle", 32'(obsRaddr), 0);
    checkOutput("validIdle", 32'(obsValid), 0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    sel        = 1'b0;
    reset      = 1'b1;
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 64; k++) memA[k] = 8'(k + 10);
    for (int k = 0; k < 16; k++) memB[k] = 8'(k + 10);
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clock);
    checkAllZero("afterReset");

    runSweep(0);
    runSweep(1);
    runSweep(2);
    runSweep(3);
    runSweep(4);
    runSweep(0);

    sel = 1'b1;
    @(negedge clock);
    runSweep(0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
